slot_round_ctrl: RTL and testbench
==================================

# slot_round_ctrl

Round controller for the FPGA slot-machine game: owns the step timer, the rotating one-hot LED position, player-press evaluation, speed level, lives and win/lose sequencing. Sits between the board switches/LEDs and the 100 MHz board clock, replacing the fixed-rate spinner with a level-scheduled game loop. All state advances on a single clock; the step rate is derived internally from the current level.

## Interface
- TICK_BASE, 25_000_000: clock cycles per LED step at level 0 (sim: 8)
- LEVELS, 4: number of speed levels; a hit at level LEVELS-1 wins the game
- LIVES_INIT, 3: lives at game start (1..3)
- FLASH_TICKS, 8: tick count of each hit/miss flash sequence
- CLOCK  input  1  board clock, all logic on rising edge
- RESET  input  1  asynchronous, active-high reset
- SWITCHES  input  4  raw player switches, asynchronous to CLOCK
- LEDS  output  4  LED ring pattern
- LEVEL  output  2  current speed level (0..LEVELS-1)
- LIVES  output  2  remaining lives
- WIN  output  1  high while in WIN state
- GAME_OVER  output  1  high while in OVER state

## Operation
- Press path: each SWITCHES bit passes 2-flop synchronizer, then rising-edge detect -> one-cycle PRESS[i]. Falling edges ignored.
- States: IDLE, SPIN, HIT_FLASH, MISS_FLASH, WIN, OVER.
- IDLE: LEDS=1010. Any PRESS -> SPIN with position 0 (LEDS=0001), LEVEL=0, LIVES=LIVES_INIT.
- SPIN: on each tick, position advances 0->1->2->3->0 (LEDS 0001,0010,0100,1000, wraps).
- SPIN press evaluation: PRESS nonzero and PRESS equals LEDS exactly -> hit; any other nonzero PRESS (wrong bit, or multiple bits) -> miss.
- Hit: if LEVEL==LEVELS-1 -> WIN; else LEVEL+1, -> HIT_FLASH.
- Miss: LIVES-1; if result is 0 -> OVER; else -> MISS_FLASH.
- HIT_FLASH: LEDS alternates 1111/0000 per tick, starting 1111, for FLASH_TICKS ticks, then -> SPIN at position 0.
- MISS_FLASH: LEDS alternates the missed position's bit/0000 per tick, FLASH_TICKS ticks, then -> SPIN at position 0. Presses ignored.
- WIN: LEDS alternates 1111/0000 per tick indefinitely; WIN=1. Any PRESS -> IDLE.
- OVER: LEDS=0000 steady; GAME_OVER=1. Any PRESS -> IDLE.
- Presses in HIT_FLASH/MISS_FLASH are discarded, not queued.

## Timing
- Reset values: LEDS=1010, LEVEL=0, LIVES=LIVES_INIT, WIN=0, GAME_OVER=0, state IDLE, timer cleared. Reset mid-round aborts immediately to these values.
- Tick period = max(TICK_BASE >> LEVEL, 1) cycles; timer 32-bit, reloaded on every state transition and on every tick.
- Press latency: SWITCHES rising edge -> PRESS pulse on 3rd CLOCK edge (2 sync + 1 edge register).
- Decision in the PRESS cycle; state, LEDS, LEVEL, LIVES update on the next edge (registered outputs).
- Press and tick in same cycle: press evaluated against current (pre-step) LEDS; step suppressed, transition wins.
- LEVEL change takes effect on the first tick after flash completes (timer reloaded at SPIN entry with new period).

## Configuration
- SLOT_ATTRACT_EN defined: IDLE LEDS alternate 1010/0101 every TICK_BASE cycles (attract mode); reset value still 1010.
- Undefined: IDLE LEDS held steady at 1010; no IDLE timer activity.

## Structure
- Shared package slot_pkg: state encoding enum, LED constants (LED_IDLE=1010, LED_ATTRACT=0101, LED_ALL=1111, LED_OFF=0000), position-to-one-hot function.
- One sub-module: slot_step_timer (load value input, tick pulse output, clear on reload); synchronizer/edge detect inline.

## Test plan
- TICK_BASE=8: reset, press SW0 -> SPIN; LEDS 0001->0010 after 8 cycles, wraps 1000->0001 after 32 cycles.
- Press SW1 while LEDS=0010 -> HIT_FLASH, LEVEL=1, 8 flash ticks of 4 cycles each, then SPIN with step period 4.
- Press SW2 while LEDS=0001 -> MISS_FLASH blinking 0001, LIVES 3->2; three misses -> OVER, GAME_OVER=1, LEDS=0000.
- SW0 and SW1 rising same cycle while LEDS=0001 -> miss, LIVES decremented.
- Four consecutive hits (levels 0..3) -> WIN=1, LEDS toggling 1111/0000 every cycle (period 8>>3=1); press -> IDLE, LEDS=1010.
- Assert RESET mid-HIT_FLASH -> next cycle LEDS=1010, LEVEL=0, LIVES=3, WIN=0.

Source files
------------

// File: rtl/slot_pkg.sv
// Shared types and constants for the slot-machine round controller.
package slot_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSpin,
        StHitFlash,
        StMissFlash,
        StWin,
        StOver
    } state_t;

    localparam logic [3:0] LED_IDLE    = 4'b1010;
    localparam logic [3:0] LED_ATTRACT = 4'b0101;
    localparam logic [3:0] LED_ALL     = 4'b1111;
    localparam logic [3:0] LED_OFF     = 4'b0000;

    function automatic logic [3:0] pos_to_onehot(input logic [1:0] pos);
        return 4'b0001 << pos;
    endfunction

    // Faster levels halve the step period, never dropping below one cycle.
    function automatic logic [31:0] step_period(input logic [31:0] base, input logic [1:0] level);
        logic [31:0] w_p;
        w_p = base >> level;
        return (w_p == 32'd0) ? 32'd1 : w_p;
    endfunction

endpackage

// File: rtl/slot_step_timer.sv
// Step timer: emits a one-cycle tick every i_period cycles; i_clear restarts the count.
module slot_step_timer (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic        i_clear,
    input  logic [31:0] i_period,
    output logic        o_tick
);

    logic [31:0] r_cnt;

    assign o_tick = i_en && (r_cnt >= (i_period - 32'd1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (!i_en || i_clear || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/slot_round_ctrl.sv
// Slot-machine round controller: press sync, spinning LED, levels, lives, win/lose.
// Define SLOT_ATTRACT_EN to blink the IDLE pattern 1010/0101 every TICK_BASE cycles.
module slot_round_ctrl
    import slot_pkg::*;
#(
    parameter int unsigned TICK_BASE   = 25_000_000,
    parameter int unsigned LEVELS      = 4,
    parameter int unsigned LIVES_INIT  = 3,
    parameter int unsigned FLASH_TICKS = 8
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic [3:0] i_switches,
    output logic [3:0] o_leds,
    output logic [1:0] o_level,
    output logic [1:0] o_lives,
    output logic       o_win,
    output logic       o_game_over
);

    localparam logic [1:0] LVL_MAX    = 2'(LEVELS - 1);
    localparam logic [1:0] LIVES_RST  = 2'(LIVES_INIT);
    localparam logic [7:0] FLASH_LAST = 8'(FLASH_TICKS - 1);

    logic [3:0]  r_sw_meta;
    logic [3:0]  r_sw_sync;
    logic [3:0]  r_sw_prev;
    logic [3:0]  r_press;
    state_t      r_state;
    logic [1:0]  r_pos;
    logic [3:0]  r_leds;
    logic [1:0]  r_level;
    logic [1:0]  r_lives;
    logic        r_win;
    logic        r_over;
    logic [7:0]  r_flash_cnt;
    logic [3:0]  r_flash_pat;

    logic        w_any_press;
    logic        w_hit;
    logic        w_tick;
    logic        w_timer_en;
    logic        w_transition;
    logic [31:0] w_period;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
            r_sw_prev <= '0;
            r_press   <= '0;
        end else begin
            r_sw_meta <= i_switches;
            r_sw_sync <= r_sw_meta;
            r_sw_prev <= r_sw_sync;
            r_press   <= r_sw_sync & ~r_sw_prev;
        end
    end

    assign w_any_press = |r_press;
    assign w_hit       = (r_press == r_leds);
    assign w_period    = (r_state == StIdle) ? 32'(TICK_BASE) : step_period(32'(TICK_BASE), r_level);

`ifdef SLOT_ATTRACT_EN
    assign w_timer_en = 1'b1;
`else
    assign w_timer_en = (r_state != StIdle);
`endif

    // Any state change restarts the step timer so each state begins a full period.
    always_comb begin
        w_transition = 1'b0;
        case (r_state)
            StIdle, StSpin, StWin, StOver: w_transition = w_any_press;
            StHitFlash, StMissFlash:       w_transition = w_tick && (r_flash_cnt == FLASH_LAST);
            default:                       w_transition = 1'b0;
        endcase
    end

    slot_step_timer u_timer (
        .i_clk    (i_clock),
        .i_rst    (i_reset),
        .i_en     (w_timer_en),
        .i_clear  (w_transition),
        .i_period (w_period),
        .o_tick   (w_tick)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_pos       <= 2'd0;
            r_leds      <= LED_IDLE;
            r_level     <= 2'd0;
            r_lives     <= LIVES_RST;
            r_win       <= 1'b0;
            r_over      <= 1'b0;
            r_flash_cnt <= '0;
            r_flash_pat <= LED_OFF;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_any_press) begin
                        r_state <= StSpin;
                        r_pos   <= 2'd0;
                        r_leds  <= pos_to_onehot(2'd0);
                        r_level <= 2'd0;
                        r_lives <= LIVES_RST;
                    end
`ifdef SLOT_ATTRACT_EN
                    else if (w_tick) begin
                        r_leds <= (r_leds == LED_IDLE) ? LED_ATTRACT : LED_IDLE;
                    end
`endif
                end
                StSpin: begin
                    // A press in a tick cycle is judged on the pre-step LED and the step is dropped.
                    if (w_any_press) begin
                        r_flash_cnt <= '0;
                        if (w_hit) begin
                            r_leds <= LED_ALL;
                            if (r_level == LVL_MAX) begin
                                r_state <= StWin;
                                r_win   <= 1'b1;
                            end else begin
                                r_state <= StHitFlash;
                                r_level <= r_level + 2'd1;
                            end
                        end else begin
                            r_lives <= r_lives - 2'd1;
                            if (r_lives == 2'd1) begin
                                r_state <= StOver;
                                r_over  <= 1'b1;
                                r_leds  <= LED_OFF;
                            end else begin
                                r_state     <= StMissFlash;
                                r_flash_pat <= r_leds;
                            end
                        end
                    end else if (w_tick) begin
                        r_pos  <= r_pos + 2'd1;
                        r_leds <= pos_to_onehot(r_pos + 2'd1);
                    end
                end
                StHitFlash, StMissFlash: begin
                    if (w_tick) begin
                        if (r_flash_cnt == FLASH_LAST) begin
                            r_state <= StSpin;
                            r_pos   <= 2'd0;
                            r_leds  <= pos_to_onehot(2'd0);
                        end else begin
                            r_flash_cnt <= r_flash_cnt + 8'd1;
                            r_leds      <= (r_leds != LED_OFF) ? LED_OFF :
                                           ((r_state == StHitFlash) ? LED_ALL : r_flash_pat);
                        end
                    end
                end
                StWin: begin
                    if (w_any_press) begin
                        r_state <= StIdle;
                        r_win   <= 1'b0;
                        r_leds  <= LED_IDLE;
                    end else if (w_tick) begin
                        r_leds <= ~r_leds;
                    end
                end
                StOver: begin
                    if (w_any_press) begin
                        r_state <= StIdle;
                        r_over  <= 1'b0;
                        r_leds  <= LED_IDLE;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_leds  <= LED_IDLE;
                end
            endcase
        end
    end

    assign o_leds      = r_leds;
    assign o_level     = r_level;
    assign o_lives     = r_lives;
    assign o_win       = r_win;
    assign o_game_over = r_over;

endmodule

// File: tb/tb_slot_round_ctrl.sv
// Self-checking bench for slot_round_ctrl: directed vector table, corner sequences, random vs model.
`timescale 1ns/1ps
module tb_slot_round_ctrl;

    localparam int TB_TICK   = 8;
    localparam int TB_LEVELS = 4;
    localparam int TB_LIVES  = 3;
    localparam int TB_FLASH  = 8;

    localparam int M_IDLE = 0;
    localparam int M_SPIN = 1;
    localparam int M_HIT  = 2;
    localparam int M_MISS = 3;
    localparam int M_WIN  = 4;
    localparam int M_OVER = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sw  = 4'b0000;
    logic [3:0] leds;
    logic [1:0] level;
    logic [1:0] lives;
    logic       win;
    logic       over;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    slot_round_ctrl #(
        .TICK_BASE   (TB_TICK),
        .LEVELS      (TB_LEVELS),
        .LIVES_INIT  (TB_LIVES),
        .FLASH_TICKS (TB_FLASH)
    ) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_switches  (sw),
        .o_leds      (leds),
        .o_level     (level),
        .o_lives     (lives),
        .o_win       (win),
        .o_game_over (over)
    );

    // Behavioural reference: game rules evaluated once per clock edge.
    int         m_mode;
    int         m_pos;
    int         m_level;
    int         m_lives;
    int         m_since;
    int         m_flashes;
    int         m_phase;
    logic [3:0] m_pat;
    logic [3:0] m_hist [4];

    function automatic logic [3:0] onehot(input int p);
        return 4'(1 << p);
    endfunction

    function automatic logic [3:0] exp_leds();
        case (m_mode)
            M_IDLE:  return 4'b1010;
            M_SPIN:  return onehot(m_pos);
            M_HIT:   return (m_flashes % 2 == 0) ? 4'b1111 : 4'b0000;
            M_MISS:  return (m_flashes % 2 == 0) ? m_pat : 4'b0000;
            M_WIN:   return (m_phase == 0) ? 4'b1111 : 4'b0000;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic model_reset();
        m_mode    = M_IDLE;
        m_pos     = 0;
        m_level   = 0;
        m_lives   = TB_LIVES;
        m_since   = 0;
        m_flashes = 0;
        m_phase   = 0;
        m_pat     = 4'b0000;
        for (int i = 0; i < 4; i++) m_hist[i] = 4'b0000;
    endtask

    task automatic model_step(input logic [3:0] s);
        logic [3:0] press;
        int         mp;
        bit         tick;
        bit         trans;
        bit         en;
        // A rising switch edge is acted on three samples after it was first seen.
        press = m_hist[2] & ~m_hist[3];
        m_hist[3] = m_hist[2];
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = s;
        en = (m_mode != M_IDLE);
        mp = TB_TICK >> m_level;
        if (mp < 1) mp = 1;
        tick  = en && (m_since + 1 >= mp);
        trans = 1'b0;
        case (m_mode)
            M_IDLE: begin
                if (press != 0) begin
                    m_mode = M_SPIN; m_pos = 0; m_level = 0; m_lives = TB_LIVES; trans = 1'b1;
                end
            end
            M_SPIN: begin
                if (press != 0) begin
                    trans = 1'b1;
                    m_flashes = 0;
                    if (press == onehot(m_pos)) begin
                        if (m_level == TB_LEVELS - 1) begin
                            m_mode = M_WIN; m_phase = 0;
                        end else begin
                            m_level++; m_mode = M_HIT;
                        end
                    end else begin
                        m_lives--;
                        m_pat  = onehot(m_pos);
                        m_mode = (m_lives == 0) ? M_OVER : M_MISS;
                    end
                end else if (tick) begin
                    m_pos = (m_pos + 1) % 4;
                end
            end
            M_HIT, M_MISS: begin
                if (tick) begin
                    m_flashes++;
                    if (m_flashes == TB_FLASH) begin
                        m_mode = M_SPIN; m_pos = 0; trans = 1'b1;
                    end
                end
            end
            M_WIN: begin
                if (press != 0) begin
                    m_mode = M_IDLE; m_phase = 0; trans = 1'b1;
                end else if (tick) begin
                    m_phase = 1 - m_phase;
                end
            end
            M_OVER: begin
                if (press != 0) begin
                    m_mode = M_IDLE; m_phase = 0; trans = 1'b1;
                end
            end
            default: m_mode = M_IDLE;
        endcase
        m_since = (!en || trans || tick) ? 0 : m_since + 1;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step(sw);
    end

    task automatic check_const(input string name, input logic [3:0] el, input logic [1:0] elv,
                               input logic [1:0] eli, input logic ew, input logic eo);
        checks++;
        if ({leds, level, lives, win, over} !== {el, elv, eli, ew, eo}) begin
            errors++;
            $display("FAIL %s: got leds=%b level=%0d lives=%0d win=%b over=%b, want leds=%b level=%0d lives=%0d win=%b over=%b",
                     name, leds, level, lives, win, over, el, elv, eli, ew, eo);
        end
    endtask

    task automatic check_model(input int cyc);
        logic [3:0] el;
        el = exp_leds();
        checks++;
        if ({leds, level, lives, win, over} !==
            {el, 2'(m_level), 2'(m_lives), (m_mode == M_WIN), (m_mode == M_OVER)}) begin
            errors++;
            $display("FAIL random cycle %0d: got leds=%b level=%0d lives=%0d win=%b over=%b, want leds=%b level=%0d lives=%0d win=%b over=%b",
                     cyc, leds, level, lives, win, over, el, m_level, m_lives,
                     (m_mode == M_WIN), (m_mode == M_OVER));
        end
    endtask

    // Hold switches for n rising edges, then settle on the falling edge.
    task automatic drive(input logic [3:0] s, input int n);
        sw = s;
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic [3:0] sw;
        int         n;
        logic [3:0] leds;
        logic [1:0] level;
        logic [1:0] lives;
        logic       win;
        logic       over;
        string      name;
    } vec_t;

    vec_t tbl [$];

    task automatic add_vec(input logic [3:0] s, input int n, input logic [3:0] el,
                           input logic [1:0] elv, input logic [1:0] eli, input logic ew,
                           input logic eo, input string name);
        vec_t v;
        v.sw = s; v.n = n; v.leds = el; v.level = elv; v.lives = eli;
        v.win = ew; v.over = eo; v.name = name;
        tbl.push_back(v);
    endtask

    initial begin
        // Edge counts in names are relative to reset release.
        add_vec(4'b0001, 1,  4'b1010, 0, 3, 0, 0, "idle_press_e1");
        add_vec(4'b0000, 2,  4'b1010, 0, 3, 0, 0, "press_latency_e3");
        add_vec(4'b0000, 1,  4'b0001, 0, 3, 0, 0, "spin_entry_e4");
        add_vec(4'b0000, 7,  4'b0001, 0, 3, 0, 0, "spin_hold_e11");
        add_vec(4'b0000, 1,  4'b0010, 0, 3, 0, 0, "spin_step_e12");
        add_vec(4'b0010, 1,  4'b0010, 0, 3, 0, 0, "hit_press_e13");
        add_vec(4'b0000, 2,  4'b0010, 0, 3, 0, 0, "hit_latency_e15");
        add_vec(4'b0000, 1,  4'b1111, 1, 3, 0, 0, "hit_flash_e16");
        add_vec(4'b0000, 3,  4'b1111, 1, 3, 0, 0, "flash_on_e19");
        add_vec(4'b0000, 1,  4'b0000, 1, 3, 0, 0, "flash_off_e20");
        add_vec(4'b0000, 27, 4'b0000, 1, 3, 0, 0, "flash_last_e47");
        add_vec(4'b0000, 1,  4'b0001, 1, 3, 0, 0, "flash_exit_e48");
        add_vec(4'b0000, 3,  4'b0001, 1, 3, 0, 0, "lvl1_hold_e51");
        add_vec(4'b0000, 1,  4'b0010, 1, 3, 0, 0, "lvl1_step_e52");
        add_vec(4'b0000, 9,  4'b1000, 1, 3, 0, 0, "lvl1_pos3_e61");
        add_vec(4'b0100, 1,  4'b1000, 1, 3, 0, 0, "miss_press_e62");
        add_vec(4'b0000, 2,  4'b0001, 1, 3, 0, 0, "lvl1_wrap_e64");
        add_vec(4'b0000, 1,  4'b0001, 1, 2, 0, 0, "miss_entry_e65");
        add_vec(4'b0000, 3,  4'b0001, 1, 2, 0, 0, "miss_on_e68");
        add_vec(4'b0000, 1,  4'b0000, 1, 2, 0, 0, "miss_off_e69");
        add_vec(4'b0000, 27, 4'b0000, 1, 2, 0, 0, "miss_last_e96");
        add_vec(4'b0000, 1,  4'b0001, 1, 2, 0, 0, "miss_exit_e97");
        add_vec(4'b0011, 1,  4'b0001, 1, 2, 0, 0, "dual_press_e98");
        add_vec(4'b0000, 3,  4'b0001, 1, 1, 0, 0, "dual_miss_e101");
        add_vec(4'b0000, 32, 4'b0001, 1, 1, 0, 0, "dual_exit_e133");
        add_vec(4'b1000, 1,  4'b0001, 1, 1, 0, 0, "last_press_e134");
        add_vec(4'b0000, 3,  4'b0000, 1, 0, 0, 1, "game_over_e137");
        add_vec(4'b0000, 5,  4'b0000, 1, 0, 0, 1, "over_steady_e142");
        add_vec(4'b0001, 1,  4'b0000, 1, 0, 0, 1, "over_press_e143");
        add_vec(4'b0000, 3,  4'b1010, 1, 0, 0, 0, "over_to_idle_e146");

        @(negedge clk);
        @(negedge clk);
        check_const("reset_values", 4'b1010, 2'd0, 2'd3, 1'b0, 1'b0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].sw, tbl[i].n);
            check_const(tbl[i].name, tbl[i].leds, tbl[i].level, tbl[i].lives, tbl[i].win,
                        tbl[i].over);
        end

        // Four hits in a row, one per level, ending in WIN.
        drive(4'b0001, 1); drive(4'b0000, 3);
        check_const("restart", 4'b0001, 2'd0, 2'd3, 1'b0, 1'b0);
        drive(4'b0000, 31);
        check_const("l0_pos3", 4'b1000, 2'd0, 2'd3, 1'b0, 1'b0);
        drive(4'b0000, 1);
        check_const("l0_wrap", 4'b0001, 2'd0, 2'd3, 1'b0, 1'b0);
        drive(4'b0001, 1); drive(4'b0000, 3);
        check_const("win_hit0", 4'b1111, 2'd1, 2'd3, 1'b0, 1'b0);
        drive(4'b0000, 32);
        check_const("win_spin1", 4'b0001, 2'd1, 2'd3, 1'b0, 1'b0);
        drive(4'b0001, 1); drive(4'b0000, 3);
        check_const("win_hit1", 4'b1111, 2'd2, 2'd3, 1'b0, 1'b0);
        drive(4'b0000, 16);
        check_const("win_spin2", 4'b0001, 2'd2, 2'd3, 1'b0, 1'b0);
        drive(4'b0010, 1); drive(4'b0000, 3);
        check_const("win_hit2", 4'b1111, 2'd3, 2'd3, 1'b0, 1'b0);
        drive(4'b0000, 8);
        check_const("win_spin3", 4'b0001, 2'd3, 2'd3, 1'b0, 1'b0);
        drive(4'b1000, 1); drive(4'b0000, 3);
        check_const("win_entry", 4'b1111, 2'd3, 2'd3, 1'b1, 1'b0);
        drive(4'b0000, 1);
        check_const("win_toggle_off", 4'b0000, 2'd3, 2'd3, 1'b1, 1'b0);
        drive(4'b0000, 1);
        check_const("win_toggle_on", 4'b1111, 2'd3, 2'd3, 1'b1, 1'b0);
        drive(4'b0100, 1); drive(4'b0000, 3);
        check_const("win_to_idle", 4'b1010, 2'd3, 2'd3, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a hit flash.
        drive(4'b0001, 1); drive(4'b0000, 3);
        drive(4'b0001, 1); drive(4'b0000, 3);
        check_const("pre_reset_flash", 4'b1111, 2'd1, 2'd3, 1'b0, 1'b0);
        drive(4'b0000, 5);
        check_const("pre_reset_flash_off", 4'b0000, 2'd1, 2'd3, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check_const("reset_mid_flash", 4'b1010, 2'd0, 2'd3, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive(4'b0000, 10);
        check_const("idle_after_reset", 4'b1010, 2'd0, 2'd3, 1'b0, 1'b0);

        // Random presses checked against the reference model every cycle.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            int r;
            check_model(c);
            r = int'($urandom_range(0, 9));
            if (r == 0)      sw = 4'($urandom_range(0, 15));
            else if (r < 3)  sw = onehot(int'($urandom_range(0, 3)));
            else             sw = 4'b0000;
            @(negedge clk);
        end
        check_model(4000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
